// File: rtl/bram_req_rsp.sv
// Byte-enabled single-port RAM with valid/ready request and response channels; BRAM_REQ_RSP_INIT_CLEAR_EN adds a post-reset zero sweep.
// Reads respond RD_LATENCY+1 cycles after acceptance; credits sized to the response FIFO stall requests instead of overflowing it.
module bram_req_rsp #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W/8-1:0]    req_we,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   wr_err
);

  localparam int BYTES      = DATA_W / 8;
  localparam int BSH        = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int CRD_W      = $clog2(FIFO_DEPTH + 1);

`ifdef BRAM_REQ_RSP_INIT_CLEAR_EN
  typedef enum logic [0:0] {ST_CLEAR, ST_RUN} state_t;
  localparam state_t RST_ST = ST_CLEAR;
`else
  typedef enum logic [0:0] {ST_RUN} state_t;
  localparam state_t RST_ST = ST_RUN;
`endif

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] widx;
  logic [IDX_W-1:0]  idx;
  logic              oor;
  logic              req_fire, wr_fire, rd_fire, rsp_pop;
  logic [DATA_W:0]   rd_word;

  logic              pipe_vld_q [RD_LATENCY];
  logic [DATA_W:0]   pipe_dat_q [RD_LATENCY];

  logic [CRD_W-1:0]  credits_q, credits_d;
  logic              wr_err_q;
  logic              f_vld;
  logic [DATA_W:0]   f_dat;

  assign widx     = req_addr >> BSH;
  assign idx      = widx[IDX_W-1:0];
  assign oor      = (widx >= ADDR_W'(DEPTH));
  assign req_fire = req_valid && req_ready;
  assign wr_fire  = req_fire && (|req_we);
  assign rd_fire  = req_fire && !(|req_we);
  assign rsp_pop  = rsp_valid && rsp_ready;
  assign rd_word  = oor ? {1'b1, {DATA_W{1'b0}}} : {1'b0, mem_q[idx]};

  // Gating with rst keeps a request offered during reset from being accepted.
  assign req_ready = !rst && (state_q == ST_RUN) && (credits_q != '0);

`ifdef BRAM_REQ_RSP_INIT_CLEAR_EN
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             clr_we;

  always_ff @(posedge clk) begin
    if (rst) clr_idx_q <= '0;
    else     clr_idx_q <= clr_idx_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= RST_ST;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef BRAM_REQ_RSP_INIT_CLEAR_EN
    clr_we    = 1'b0;
    clr_idx_d = clr_idx_q;
    if (state_q == ST_CLEAR) begin
      clr_we    = 1'b1;
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
`ifdef BRAM_REQ_RSP_INIT_CLEAR_EN
      if (clr_we) mem_q[clr_idx_q] <= '0;
`endif
      if (wr_fire && !oor) begin
        for (int b = 0; b < BYTES; b++) begin
          if (req_we[b]) mem_q[idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Stage 0 is the synchronous array read; later stages only add delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_dat_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= rd_fire;
      pipe_dat_q[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_dat_q[i] <= pipe_dat_q[i-1];
      end
    end
  end

  always_comb begin
    credits_d = credits_q;
    if (rd_fire && !rsp_pop)      credits_d = credits_q - 1'b1;
    else if (!rd_fire && rsp_pop) credits_d = credits_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q <= CRD_W'(FIFO_DEPTH);
      wr_err_q  <= 1'b0;
    end else begin
      credits_q <= credits_d;
      if (wr_fire && oor) wr_err_q <= 1'b1;
    end
  end

  bram_req_rsp_fifo #(
    .W (DATA_W + 1),
    .D (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (pipe_vld_q[RD_LATENCY-1]),
    .push_dat_i (pipe_dat_q[RD_LATENCY-1]),
    .pop_i      (rsp_pop),
    .out_vld_o  (f_vld),
    .out_dat_o  (f_dat)
  );

  assign rsp_valid = f_vld;
  assign rsp_rdata = f_vld ? f_dat[DATA_W-1:0] : '0;
  assign rsp_err   = f_vld && f_dat[DATA_W];
  assign wr_err    = wr_err_q;

endmodule

module bram_req_rsp_fifo #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic         out_vld_o,
  output logic [W-1:0] out_dat_o
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  logic [W-1:0]  mem_q [D];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= nxt(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= nxt(rd_ptr_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !rst) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign out_vld_o = (cnt_q != '0);
  assign out_dat_o = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_bram_req_rsp.sv
// Directed bench for bram_req_rsp: writes, byte enables, range errors, backpressure, reset flush.
module tb_bram_req_rsp;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 32;
  localparam int LAT    = 1;
`ifdef BRAM_REQ_RSP_INIT_CLEAR_EN
  localparam int CLR_CYC = DEPTH;
  localparam bit CLR     = 1'b1;
`else
  localparam int CLR_CYC = 0;
  localparam bit CLR     = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_we;
  logic [63:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_rdata;
  logic              rsp_err;
  logic              wr_err;

  int checks = 0;
  int errors = 0;

  bram_req_rsp #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .RD_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wr_err    (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_addr  = '0;
    req_we    = '0;
    req_wdata = '0;
  endtask

  task automatic wait_ready_after_rst();
    #1;
    for (int k = 0; k < CLR_CYC; k++) begin
      chk("ready_low_during_clear", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
    end
    chk("ready_after_rst", {63'd0, req_ready}, 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_err",   {63'd0, rsp_err}, 64'd0);
    chk("rst_wr_err",    {63'd0, wr_err}, 64'd0);
    rst = 1'b0;
    wait_ready_after_rst();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] we, input logic [63:0] data);
    chk("wr_req_ready", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_we    = we;
    req_wdata = data;
    @(negedge clk);
    idle();
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [63:0] exp, input logic exp_err);
    chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_we    = '0;
    @(negedge clk);
    idle();
    for (int k = 0; k < LAT; k++) begin
      chk({tag, "_early"}, {63'd0, rsp_valid}, 64'd0);
      @(negedge clk);
    end
    chk({tag, "_valid"}, {63'd0, rsp_valid}, 64'd1);
    chk({tag, "_rdata"}, rsp_rdata, exp);
    chk({tag, "_err"},   {63'd0, rsp_err}, {63'd0, exp_err});
    @(negedge clk);
    chk({tag, "_drained"}, {63'd0, rsp_valid}, 64'd0);
  endtask

  logic [63:0] bp_exp [3];

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b1;
    idle();
    do_reset();

    for (int i = 0; i < 5; i++) do_write(32'(i * 8), 8'hFF, 64'h1234 + 64'(i));
    for (int i = 0; i < 5; i++) do_read("rd_seq", 32'(i * 8), 64'h1234 + 64'(i), 1'b0);

    do_write(32'h10, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    do_write(32'h10, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB);
    do_read("rd_partial", 32'h10, 64'hFFFF_FFFF_BBBB_BBBB, 1'b0);

    do_read("rd_oor", 32'h100, 64'd0, 1'b1);
    chk("wr_err_clear", {63'd0, wr_err}, 64'd0);
    do_write(32'h108, 8'hFF, 64'hDEAD_BEEF);
    chk("wr_err_set", {63'd0, wr_err}, 64'd1);
    do_read("rd_word0", 32'h00, 64'h1234, 1'b0);
    chk("wr_err_sticky", {63'd0, wr_err}, 64'd1);

    // Backpressure: three credits, then req_ready must fall.
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1;
      req_addr  = 32'(k * 8);
      req_we    = '0;
      chk("bp_req_ready", {63'd0, req_ready}, (k < 3) ? 64'd1 : 64'd0);
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      chk("bp_stall_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_stall_rdata", rsp_rdata, 64'h1234);
      @(negedge clk);
    end
    bp_exp[0] = 64'h1234;
    bp_exp[1] = 64'h1235;
    bp_exp[2] = 64'hFFFF_FFFF_BBBB_BBBB;
    rsp_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk("bp_drain_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_drain_rdata", rsp_rdata, bp_exp[j]);
      @(negedge clk);
    end
    chk("bp_empty", {63'd0, rsp_valid}, 64'd0);
    chk("bp_credits_back", {63'd0, req_ready}, 64'd1);

    do_write(32'h28, 8'hFF, 64'h55);

    // Reset with three reads outstanding plus a write offered during rst.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rr_req_ready", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1;
      req_addr  = 32'(k * 8);
      req_we    = '0;
      @(negedge clk);
    end
    rst       = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    req_we    = 8'hFF;
    req_wdata = 64'hDEAD;
    #1;
    chk("rr_ready_in_rst", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("rr_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rr_wr_err", {63'd0, wr_err}, 64'd0);
    wait_ready_after_rst();
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rr_no_stale", {63'd0, rsp_valid}, 64'd0);
    end
    do_read("rr_word0", 32'h00, CLR ? 64'd0 : 64'h1234, 1'b0);
    do_read("rr_word5", 32'h28, CLR ? 64'd0 : 64'h55, 1'b0);
    do_read("rr_word4", 32'h20, CLR ? 64'd0 : 64'h1238, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (checks %0d, errors %0d)", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bram_req_rsp.md
Name: bram_req_rsp

Overview:
- Parametrised single-port synchronous RAM with byte write enables, byte addressing and valid/ready request and response channels.
- Successor to the bare block-memory primitive. Adds:
  - configurable read latency;
  - response backpressure via credit-tracked output FIFO;
  - out-of-range detection;
  - optional post-reset clear sweep.
- Sits between the sampler/accumulator datapath and on-chip storage.

Parameters:
- DATA_W, 64, data width in bits; multiple of 8.
- DEPTH, 32, number of words; power of two.
- ADDR_W, 32, byte-address width.
- RD_LATENCY, 1, cycles from read acceptance to data entering output FIFO; range 1..4.
- BYTES, DATA_W/8, derived; byte-enable width.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&&ready.
- req_addr  in  ADDR_W  byte address; low log2(BYTES) bits ignored.
- req_we  in  BYTES  byte write enables; all-zero = read.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  response consumed when valid&&ready.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  response address was out of range.
- wr_err  out  1  sticky: an out-of-range write was dropped.

Behaviour:
- Word index = req_addr >> log2(BYTES). Out of range iff index >= DEPTH.
- Reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wr_err=0. Pipeline valids, FIFO pointers and count cleared; credits=FIFO_DEPTH. Memory contents retained unless INIT_CLEAR_EN.
- FIFO_DEPTH = RD_LATENCY+2.
- One request accepted per cycle, processed strictly in order.
- req_ready = (state==RUN) && (credits>0). It is independent of req_valid and of request type.
- Write (req_we!=0), accepted:
  - In range: bytes with req_we[i]=1 are updated at that clock edge; other bytes are unchanged.
  - No response is produced and no credit is consumed.
  - Out of range: memory is untouched and wr_err is set to 1 until rst.
- Read (req_we==0), accepted:
  - Consumes one credit.
  - Data and error flag travel an RD_LATENCY-stage valid pipeline, then enter the FIFO.
  - Out-of-range reads return rdata=0 and err=1.
- Credit accounting:
  - Credit returned on rsp_valid&&rsp_ready.
  - Simultaneous read acceptance and response pop: net credits unchanged.
  - Credits never exceed FIFO_DEPTH and never go below 0.
- Response timing:
  - Head of FIFO drives rsp_*. With rsp_ready held high, the first response appears RD_LATENCY+1 cycles after read acceptance.
  - rsp_rdata and rsp_err are stable while rsp_valid && !rsp_ready.
- Read after write to the same word in any later cycle returns the new data.
- Back-to-back reads with rsp_ready=1 sustain one response per cycle.
- FIFO full can never overflow (guaranteed by credits). FIFO empty gives rsp_valid=0.
- rst mid-operation: in-flight reads and queued responses are discarded and the FIFO pointers wrap to 0. A write accepted in the same cycle as rst is not performed.
- States: CLEAR (only with macro) -> RUN. Without the macro, reset enters RUN and req_ready rises in the first cycle after rst deasserts.

Optional Feature:
- Macro BRAM_REQ_RSP_INIT_CLEAR_EN.
- Defined:
  - After rst, the FSM enters CLEAR and a counter writes 0 to words 0..DEPTH-1, one per cycle.
  - req_ready=0 throughout; RUN is entered after word DEPTH-1 is written.
  - req_ready first rises DEPTH cycles after rst deasserts.
  - rst during CLEAR restarts the sweep at word 0.
- Undefined:
  - No CLEAR state and no sweep counter.
  - Contents after reset are unspecified (initial-load or previous values).

Test Plan:
- Reset, then write 0x1234/0x1235/0x1236/0x1237/0x1238 to 0x00/0x08/0x10/0x18/0x20 with we=0xFF. Read 0x00..0x20 with rsp_ready=1 -> same values in order, each RD_LATENCY+1 cycles after acceptance.
- Write 0xFFFFFFFFFFFFFFFF to 0x10, then write 0xAAAAAAAABBBBBBBB with we=0x0F, then read 0x10 -> 0xFFFFFFFFBBBBBBBB.
- Read 0x100 (DEPTH=32) -> rsp_rdata=0, rsp_err=1. Write 0x108 -> wr_err=1 and stays 1 until rst; word 0 unchanged.
- rsp_ready=0 while issuing reads -> req_ready drops after exactly RD_LATENCY+2 read acceptances. Raise rsp_ready -> all responses in order, no loss or duplication, and rsp_rdata held stable while stalled.
- Pulse rst with 3 reads outstanding -> rsp_valid=0 the cycle after reset. Reads after reset return correct data with no stale responses.
- With BRAM_REQ_RSP_INIT_CLEAR_EN: preload word 5, reset -> req_ready=0 for 32 cycles after rst deasserts; read 0x28 -> 0.
